// File: rtl/dac_pkg.sv
// dac_pkg: shared constants and types for the multi-channel DAC ramp block.
// Frame width, SPI write command, sequencer states, channel-index width.
package dac_pkg;

    localparam int         FRAME_W    = 24;
    localparam logic [3:0] CMD_WR_UPD = 4'h3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_LDAC
    } state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_multi_ramp_if.sv
// dac_multi_ramp_if: pin bundle to the external multi-channel SPI DAC.
// master = controller side (drives SDI/SCK/CSn/LDAc/CLRn, reads SDO).
interface dac_multi_ramp_if;

    logic SDO;
    logic SDI;
    logic SCK;
    logic CSn;
    logic LDAc;
    logic CLRn;

    modport master (
        input  SDO,
        output SDI, SCK, CSn, LDAc, CLRn
    );

    modport slave (
        output SDO,
        input  SDI, SCK, CSn, LDAc, CLRn
    );

endinterface

// File: rtl/dac_spi_frame.sv
// dac_spi_frame: one 24-bit MSB-first SPI write frame, SCK idle high.
// Ports: start/frame in, done (last cycle of frame), sdi/sck/csn out;
// with DAC_READBACK_EN also sdo in, rdback/rdback_vld out.
module dac_spi_frame
    import dac_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               done,
    output logic               sdi,
    output logic               sck,
    output logic               csn
`ifdef DAC_READBACK_EN
    ,
    input  logic               sdo,
    output logic [FRAME_W-1:0] rdback,
    output logic               rdback_vld
`endif
);

    localparam int              DIVW     = $clog2(SCK_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCK_DIV - 1);
    // 49 half-period slots: slot 0 is CSn-to-first-fall lead,
    // odd slots are SCK low, even slots SCK high; slot 48 ends the frame.
    localparam logic [5:0]      HP_LAST  = 6'd48;

    logic               active_q, active_d;
    logic [DIVW-1:0]    div_q, div_d;
    logic [5:0]         hp_q, hp_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic               sdi_q, sdi_d;
    logic               sck_q, sck_d;
    logic               csn_q, csn_d;
    logic               tick;

    assign tick = active_q && (div_q == DIV_LAST);
    assign done = tick && (hp_q == HP_LAST);

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        hp_d     = hp_q;
        sr_d     = sr_q;
        sdi_d    = sdi_q;
        sck_d    = sck_q;
        csn_d    = csn_q;
        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            hp_d     = '0;
            sr_d     = frame;
            sdi_d    = frame[FRAME_W-1];
            sck_d    = 1'b1;
            csn_d    = 1'b0;
        end else if (active_q) begin
            div_d = div_q + 1'b1;
            if (tick) begin
                div_d = '0;
                hp_d  = hp_q + 6'd1;
                if (done) begin
                    active_d = 1'b0;
                    csn_d    = 1'b1;
                    sck_d    = 1'b1;
                    sdi_d    = 1'b0;
                end else if (!hp_q[0]) begin
                    // falling edge: present next bit
                    sck_d = 1'b0;
                    sdi_d = sr_q[FRAME_W-1];
                    sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
                end else begin
                    sck_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            active_q <= 1'b0;
            div_q    <= '0;
            hp_q     <= '0;
            sr_q     <= '0;
            sdi_q    <= 1'b0;
            sck_q    <= 1'b1;
            csn_q    <= 1'b1;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            hp_q     <= hp_d;
            sr_q     <= sr_d;
            sdi_q    <= sdi_d;
            sck_q    <= sck_d;
            csn_q    <= csn_d;
        end
    end

    assign sdi = sdi_q;
    assign sck = sck_q;
    assign csn = csn_q;

`ifdef DAC_READBACK_EN
    logic [FRAME_W-1:0] rd_sr_q, rd_sr_d;
    logic [FRAME_W-1:0] rdback_q, rdback_d;
    logic               rd_vld_q;

    always_comb begin
        rd_sr_d  = rd_sr_q;
        rdback_d = rdback_q;
        // odd slot ending means SCK rises: DAC output is stable
        if (tick && hp_q[0]) begin
            rd_sr_d = {rd_sr_q[FRAME_W-2:0], sdo};
        end
        if (done) begin
            rdback_d = rd_sr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_sr_q  <= '0;
            rdback_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_sr_q  <= rd_sr_d;
            rdback_q <= rdback_d;
            rd_vld_q <= done;
        end
    end

    assign rdback     = rdback_q;
    assign rdback_vld = rd_vld_q;
`endif

endmodule

// File: rtl/dac_multi_ramp.sv
// dac_multi_ramp: NCH fixed/ramping DAC codes, framed over SPI per sync.
// Ports: clk, rst_l, sync, en, mode, target, step -> code, ramp_done,
// busy, overrun; DAC pins via dac_multi_ramp_if.master. Optional
// DAC_READBACK_EN adds rdback/rdback_vld. Requires CS_GAP >= 2.
module dac_multi_ramp
    import dac_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int SCK_DIV = 4,
    parameter int CS_GAP  = 4,
    parameter int LDAC_W  = 2
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              sync,
    input  logic              en,
    input  logic [NCH-1:0]    mode,
    input  logic [NCH*DW-1:0] target,
    input  logic [DW-1:0]     step,
    output logic [NCH*DW-1:0] code,
    output logic [NCH-1:0]    ramp_done,
    output logic              busy,
    output logic              overrun,
    dac_multi_ramp_if.master  dac
`ifdef DAC_READBACK_EN
    ,
    output logic [FRAME_W-1:0] rdback,
    output logic               rdback_vld
`endif
);

    localparam int CHW  = ch_w(NCH);
    localparam int CMAX = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
    localparam int CNTW = $clog2(CMAX + 1);

    localparam logic [CHW-1:0]  CH_LAST   = CHW'(NCH - 1);
    // the LOAD cycle is part of the inter-frame CSn-high gap
    localparam logic [CNTW-1:0] GAP_NEXT  = CNTW'(CS_GAP - 2);
    localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(CS_GAP - 1);
    localparam logic [CNTW-1:0] LDAC_LAST = CNTW'(LDAC_W - 1);

    state_t                  state_q;
    logic [CHW-1:0]          ch_q;
    logic [CNTW-1:0]         cnt_q;
    logic                    busy_q;
    logic                    ldac_q;
    logic                    ovr_q;
    logic                    clrn_q;
    logic [NCH-1:0][DW-1:0]  code_q, code_d;
    logic [NCH-1:0]          rdone_q, rdone_d;
    logic [15:0]             data16;
    logic [FRAME_W-1:0]      frame;
    logic                    frm_start;
    logic                    frm_done;
    logic                    last_ch;

    function automatic logic [DW-1:0] ramp_next(
        input logic [DW-1:0] c,
        input logic [DW-1:0] t,
        input logic [DW-1:0] s
    );
        logic [DW:0]   cx, tx, sx, up, dn;
        logic [DW-1:0] res;
        cx  = {1'b0, c};
        tx  = {1'b0, t};
        sx  = {1'b0, s};
        up  = cx + sx;
        dn  = (cx > sx) ? (cx - sx) : '0;
        res = c;
        if (cx < tx) begin
            res = (up > tx) ? t : up[DW-1:0];
        end else if (cx > tx) begin
            res = (dn < tx) ? t : dn[DW-1:0];
        end
        return res;
    endfunction

    always_comb begin
        code_d  = code_q;
        rdone_d = rdone_q;
        if (state_q == S_CALC) begin
            for (int i = 0; i < NCH; i++) begin
                code_d[i] = mode[i]
                    ? ramp_next(code_q[i], target[i*DW +: DW], step)
                    : target[i*DW +: DW];
                rdone_d[i] = mode[i] && (code_d[i] == target[i*DW +: DW]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            code_q  <= '0;
            rdone_q <= '0;
            clrn_q  <= 1'b0;
        end else begin
            code_q  <= code_d;
            rdone_q <= rdone_d;
            clrn_q  <= 1'b1;
        end
    end

    assign last_ch   = (ch_q == CH_LAST);
    assign data16    = 16'(code_q[ch_q]) << (16 - DW);
    assign frame     = {CMD_WR_UPD, 4'(ch_q), data16};
    assign frm_start = (state_q == S_LOAD) && en;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ldac_q  <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            if (sync && en && busy_q) begin
                ovr_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (sync && en) begin
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                        ch_q    <= '0;
                    end
                end
                S_CALC: state_q <= S_LOAD;
                S_LOAD: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (frm_done) begin
                        cnt_q <= '0;
                        if (!en) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_ch && cnt_q == GAP_LAST) begin
                        state_q <= S_LDAC;
                        ldac_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (!last_ch && cnt_q == GAP_NEXT) begin
                        state_q <= S_LOAD;
                        ch_q    <= ch_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LDAC: begin
                    if (cnt_q == LDAC_LAST) begin
                        state_q <= S_IDLE;
                        ldac_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    dac_spi_frame #(
        .SCK_DIV (SCK_DIV)
    ) u_frame (
        .clk        (clk),
        .rst_l      (rst_l),
        .start      (frm_start),
        .frame      (frame),
        .done       (frm_done),
        .sdi        (dac.SDI),
        .sck        (dac.SCK),
        .csn        (dac.CSn)
`ifdef DAC_READBACK_EN
        ,
        .sdo        (dac.SDO),
        .rdback     (rdback),
        .rdback_vld (rdback_vld)
`endif
    );

    assign dac.LDAc  = ldac_q;
    assign dac.CLRn  = clrn_q;
    assign code      = code_q;
    assign ramp_done = rdone_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_dac_multi_ramp.sv
// tb_dac_multi_ramp: directed checks of framing, ramps, overrun, reset.
// SPI pins are decoded by a small DAC model that also echoes frames on SDO.
module tb_dac_multi_ramp;

    localparam int NCH  = 4;
    localparam int DW   = 16;
    localparam int BLEN = 2 + NCH * (48 * 4 + 4 + 4) + 2;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic              sync = 1'b0;
    logic              en = 1'b1;
    logic [NCH-1:0]    mode = '0;
    logic [NCH*DW-1:0] target = '0;
    logic [DW-1:0]     step = '0;
    logic [NCH*DW-1:0] code;
    logic [NCH-1:0]    ramp_done;
    logic              busy;
    logic              overrun;
`ifdef DAC_READBACK_EN
    logic [23:0]       rdback;
    logic              rdback_vld;
`endif

    int n_chk = 0;
    int n_pass = 0;

    int          nbits = 0;
    logic [23:0] cur = '0;
    logic [23:0] last_frame = '0;
    logic [23:0] sh_sdo = '0;
    logic [23:0] exp_rd = '0;
    logic [23:0] frames[$];
    time         t_csn = 0;
    time         t_ldac = 0;
    int          nldac = 0;
    int          bcnt = 0;

    logic [15:0] ramp_c[4] = '{16'h0006, 16'h000C, 16'h0010, 16'h0010};
    logic        ramp_r[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    dac_multi_ramp_if ifc ();

    dac_multi_ramp #(
        .NCH(NCH), .DW(DW), .SCK_DIV(4), .CS_GAP(4), .LDAC_W(2)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .sync      (sync),
        .en        (en),
        .mode      (mode),
        .target    (target),
        .step      (step),
        .code      (code),
        .ramp_done (ramp_done),
        .busy      (busy),
        .overrun   (overrun),
        .dac       (ifc)
`ifdef DAC_READBACK_EN
        ,
        .rdback     (rdback),
        .rdback_vld (rdback_vld)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge ifc.CSn) begin
        nbits  = 0;
        sh_sdo = last_frame;
        exp_rd = last_frame;
    end

    always @(negedge ifc.SCK) begin
        ifc.SDO = sh_sdo[23];
        sh_sdo  = {sh_sdo[22:0], 1'b0};
    end

    always @(posedge ifc.SCK) begin
        if (ifc.CSn === 1'b0) begin
            cur = {cur[22:0], ifc.SDI};
            nbits++;
        end
    end

    always @(posedge ifc.CSn) begin
        if (nbits == 24) begin
            frames.push_back(cur);
            last_frame = cur;
            t_csn = $time;
`ifdef DAC_READBACK_EN
            #1;
            chk("rd_vld", rdback_vld, 1);
            chk("rdback", rdback, exp_rd);
`endif
        end
    end

    always @(negedge ifc.LDAc) begin
        nldac++;
        t_ldac = $time;
    end

    always @(negedge clk) if (busy === 1'b1) bcnt++;

    task automatic do_sync();
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic run_seq();
        frames.delete();
        nldac = 0;
        bcnt  = 0;
        do_sync();
        wait_idle();
        @(negedge clk);
    endtask

    task automatic chk_frames(input string tag, input logic [3:0][23:0] e);
        chk({tag, "_n"}, frames.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_f%0d", tag, i),
                (i < frames.size()) ? frames[i] : 24'h0, e[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ifc.SDO = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_code", code, 0);
        chk("rst_rdone", ramp_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_sdi", ifc.SDI, 0);
        chk("rst_sck", ifc.SCK, 1);
        chk("rst_csn", ifc.CSn, 1);
        chk("rst_ldac", ifc.LDAc, 1);
        chk("rst_clrn", ifc.CLRn, 0);
        rst_l = 1'b1;
        @(negedge clk);
        chk("clrn_rel", ifc.CLRn, 1);

        // fixed codes on all channels
        target = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        run_seq();
        chk_frames("t1", {24'h334444, 24'h323333, 24'h312222, 24'h301111});
        chk("t1_busy_len", bcnt, BLEN);
        chk("t1_nldac", nldac, 1);
        chk("t1_ldac_gap", t_ldac - t_csn, 40);
        chk("t1_code", code, {16'h4444, 16'h3333, 16'h2222, 16'h1111});

        // ch0 ramp up 0 -> 0x10 by 6
        target[15:0] = 16'h0000;
        run_seq();
        chk("t2_zero", code[15:0], 0);
        mode = 4'b0001;
        target[15:0] = 16'h0010;
        step = 16'd6;
        for (int k = 0; k < 4; k++) begin
            run_seq();
            chk($sformatf("t2_code%0d", k), code[15:0], ramp_c[k]);
            chk($sformatf("t2_done%0d", k), ramp_done[0], ramp_r[k]);
        end
        chk("t2_frame0", frames.size() > 0 ? frames[0] : 24'h0, 24'h300010);

        // ch1 ramp down without wrap, ramp up with saturation
        mode = 4'b0000;
        target[31:16] = 16'h0005;
        run_seq();
        chk("t3_load5", code[31:16], 16'h0005);
        mode = 4'b0010;
        target[31:16] = 16'h0000;
        step = 16'hFFFF;
        run_seq();
        chk("t3_down", code[31:16], 16'h0000);
        chk("t3_down_done", ramp_done[1], 1);
        mode = 4'b0000;
        target[31:16] = 16'hFFF0;
        run_seq();
        mode = 4'b0010;
        target[31:16] = 16'hFFFF;
        step = 16'h0020;
        run_seq();
        chk("t3_up_sat", code[31:16], 16'hFFFF);
        chk("t3_frame1", frames.size() > 1 ? frames[1] : 24'h0, 24'h31FFFF);

        // second sync while shifting
        mode = 4'b0000;
        target = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        frames.delete();
        nldac = 0;
        bcnt = 0;
        do_sync();
        repeat (100) @(negedge clk);
        chk("t4_ovr_pre", overrun, 0);
        do_sync();
        chk("t4_ovr_set", overrun, 1);
        wait_idle();
        @(negedge clk);
        chk_frames("t4", {24'h33DDDD, 24'h32CCCC, 24'h31BBBB, 24'h30AAAA});
        chk("t4_busy_len", bcnt, BLEN);
        run_seq();
        chk("t4_ovr_sticky", overrun, 1);

        // reset in the middle of frame 2
        target = {16'h4004, 16'h3003, 16'h2002, 16'h1001};
        frames.delete();
        do_sync();
        for (int n = 0; n < 1000 && frames.size() < 1; n++) @(negedge clk);
        chk("t5_frame1_seen", frames.size(), 1);
        repeat (60) @(negedge clk);
        rst_l = 1'b0;
        #1;
        chk("t5_csn", ifc.CSn, 1);
        chk("t5_sck", ifc.SCK, 1);
        chk("t5_ldac", ifc.LDAc, 1);
        chk("t5_clrn", ifc.CLRn, 0);
        chk("t5_code", code, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ovr", overrun, 0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        run_seq();
        chk_frames("t5", {24'h334004, 24'h323003, 24'h312002, 24'h301001});
        chk("t5_nldac", nldac, 1);
        chk("t5_busy_len", bcnt, BLEN);

        // strobe ignored while disabled
        en = 1'b0;
        do_sync();
        chk("t6_en_off", busy, 0);
        en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
